// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader and run supervisor for the CPU ROM.
//   Receives a framed byte stream (0xA5, LEN lo, LEN hi, LEN words of data
//   LSB first, optional checksum byte) and packs the data into WORD_W-bit
//   little-endian words. The words are written to ROM from address 0 while
//   the CPU is held in reset. The CPU is then released and watched until it
//   halts (done) or the cycle budget runs out (timeout).
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing 8-bit
//   wrapping-sum checksum byte. A mismatch gives err_code 2.
// Ports:
//   clk         system clock
//   reset       synchronous active-low reset
//   rx_valid    one-cycle strobe qualifying rx_data
//   rx_data     received byte
//   cpu_halted  level, CPU has executed halt
//   mem_we      ROM write strobe, one cycle per word
//   mem_addr    ROM write address
//   mem_wdata   ROM write data
//   cpu_rst_n   CPU reset, active-low
//   busy        frame being loaded or program running
//   done        CPU halted within budget
//   timeout     sticky, budget exhausted; cleared by next frame or reset
//   err         frame rejected
//   err_code    0 none, 1 bad length, 2 checksum mismatch
module prog_loader #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MAX_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              cpu_halted,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned BYTES = WORD_W / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_RUN, S_DONE, S_ERR
`ifdef PROG_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_e;

  state_e state_q, state_d;

  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [31:0]       cyc_q, cyc_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic        is_hdr, len_bad, word_last, frame_last, budget_end, start;
  logic [15:0] len_full;

  assign is_hdr     = rx_valid && (rx_data == 8'hA5);
  assign len_full   = {rx_data, len_lo_q};
  assign len_bad    = (len_full == 16'd0) || ({16'd0, len_full} > (32'd1 << ADDR_W));
  assign word_last  = (byte_idx_q == IDX_W'(BYTES - 1));
  assign frame_last = word_last && (wcnt_q == 16'd1);
  assign budget_end = (cyc_q == 32'(MAX_CYCLES - 1));
  // Only a header byte can move the FSM into LEN_LO.
  assign start      = (state_d == S_LEN_LO) && (state_q != S_LEN_LO);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (is_hdr) state_d = S_LEN_LO;
      S_LEN_LO: if (rx_valid) state_d = S_LEN_HI;
      S_LEN_HI: if (rx_valid) state_d = len_bad ? S_ERR : S_DATA;
      S_DATA: begin
        if (rx_valid && frame_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_RUN;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      // csum_q already includes every data byte when this byte arrives.
      S_CSUM: if (rx_valid) state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
`endif
      // A new header restarts loading; halt beats a simultaneous budget end.
      S_RUN: begin
        if (is_hdr)          state_d = S_LEN_LO;
        else if (cpu_halted) state_d = S_DONE;
        else if (budget_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    len_lo_d   = len_lo_q;
    wcnt_d     = wcnt_q;
    waddr_d    = waddr_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    cyc_d      = (state_q == S_RUN) ? cyc_q + 32'd1 : '0;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d     = start ? '0 : csum_q;
`endif
    if (rx_valid) begin
      case (state_q)
        S_LEN_LO: len_lo_d = rx_data;
        S_LEN_HI: begin
          wcnt_d     = len_full;
          waddr_d    = '0;
          byte_idx_d = '0;
          word_d     = '0;
        end
        S_DATA: begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q + rx_data;
`endif
          if (word_last) begin
            byte_idx_d = '0;
            wcnt_d     = wcnt_q - 16'd1;
            waddr_d    = waddr_q + 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic; every output is registered from the next state.
  always_comb begin
    mem_we_d    = (state_q == S_DATA) && rx_valid && word_last;
    mem_addr_d  = mem_we_d ? waddr_q : mem_addr_q;
    mem_wdata_d = mem_we_d ? word_d  : mem_wdata_q;
    cpu_rst_n_d = (state_d == S_RUN) || (state_d == S_DONE);
    busy_d      = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                  (state_d == S_DATA)   || (state_d == S_RUN)
`ifdef PROG_LOADER_CHECKSUM_EN
                  || (state_d == S_CSUM)
`endif
                  ;
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    timeout_d   = timeout_q;
    err_code_d  = err_code_q;
    if (start) begin
      timeout_d  = 1'b0;
      err_code_d = 2'd0;
    end
    if ((state_q == S_RUN) && (state_d == S_IDLE)) timeout_d = 1'b1;
    if ((state_q == S_LEN_HI) && (state_d == S_ERR)) err_code_d = 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
    if ((state_q == S_CSUM) && (state_d == S_ERR)) err_code_d = 2'd2;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len_lo_q    <= '0;
      wcnt_q      <= '0;
      waddr_q     <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      cyc_q       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      len_lo_q    <= len_lo_d;
      wcnt_q      <= wcnt_d;
      waddr_q     <= waddr_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      cyc_q       <= cyc_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
